// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the load/store unit.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 is illegal)
//   - FSM state enum (IDLE / WAIT / RESP)
//   - ld_extend(): sign/zero extension of a right-aligned load lane
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // lane holds the addressed byte/half already shifted down to bit 0.
  // Word loads pass through untouched, so ld_unsigned has no effect on them.
  function automatic logic [31:0] ld_extend(input logic [31:0] lane,
                                            input logic [1:0]  size,
                                            input logic        ld_unsigned);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = {{24{~ld_unsigned & lane[7]}},  lane[7:0]};
      SZ_HALF: res = {{16{~ld_unsigned & lane[15]}}, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word memory with byte-enable write and synchronous
// read. The read data register updates on every enabled cycle (read-first).
// The array itself is never reset.
// Ports:
//   clk      clock, rising edge
//   en_i     access enable (read and/or write this edge)
//   be_i     byte-lane write enables, bit n covers wdata_i[8n+7:8n]
//   idx_i    word index
//   wdata_i  lane-replicated write data
//   rdata_o  registered read data (old contents on a write cycle)
module dmem_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_o <= mem_q[idx_i];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit with on-chip data memory and a wait-state FSM.
// Byte/half/word loads (sign or zero extended) and byte-lane stores.
// Optional feature macro: DMEM_PERF_EN adds perf_loads_o/perf_stores_o/
// perf_stalls_o event counters.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req_i            access request, sampled only in IDLE
//   we_i             1 = store, 0 = load
//   size_i           00 byte, 01 half, 10 word, 11 illegal
//   ld_unsigned_i    1 = zero-extend loads
//   addr_i, wdata_i  byte address; right-aligned store data
//   rdata_o          load result, held until the next load completes
//   busy_o           stall to the core
//   done_o           one-cycle completion pulse
//   misalign_o       fault flag, valid with done_o
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        done_o,
`ifdef DMEM_PERF_EN
  output logic [31:0] perf_loads_o,
  output logic [31:0] perf_stores_o,
  output logic [31:0] perf_stalls_o,
`endif
  output logic        misalign_o
);

  localparam int AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, uns_q, fault_q, misalign_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q, rdata_q;

  logic          aligned, accept, fault_now, legal_now, access;
  logic          acc_we;
  logic [1:0]    acc_size;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata, ram_wdata, ram_rdata;
  logic [3:0]    ram_be;
  logic          unused_addr_hi;

  // Upper address bits are intentionally dropped: addresses wrap.
  assign unused_addr_hi = ^addr_i[31:AW+2];

  assign aligned   = (size_i == SZ_BYTE) ||
                     (size_i == SZ_HALF && !addr_i[0]) ||
                     (size_i == SZ_WORD && addr_i[1:0] == 2'b00);
  assign accept    = (state_q == IDLE) && req_i;
  assign fault_now = accept && !aligned;
  assign legal_now = accept && aligned;

  // The memory edge is either the accept edge (no wait states) or the last
  // WAIT edge. Fields come straight from the inputs in the first case.
  assign access    = (legal_now && WAIT_CYCLES == 0) ||
                     (state_q == WAIT && cnt_q == 4'd1);
  assign acc_we    = (state_q == IDLE) ? we_i           : we_q;
  assign acc_size  = (state_q == IDLE) ? size_i         : size_q;
  assign acc_addr  = (state_q == IDLE) ? addr_i[AW+1:0] : addr_q;
  assign acc_wdata = (state_q == IDLE) ? wdata_i        : wdata_q;

  // Replicate store data across lanes so the byte enables pick the target.
  always_comb begin
    ram_be    = 4'b1111;
    ram_wdata = acc_wdata;
    case (acc_size)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << acc_addr[1:0];
        ram_wdata = {4{acc_wdata[7:0]}};
      end
      SZ_HALF: begin
        ram_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{acc_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!acc_we) ram_be = 4'b0000;
  end

  // rst gating keeps a zero-wait access from landing while reset is held.
  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .en_i    (access && !rst),
    .be_i    (ram_be),
    .idx_i   (acc_addr[AW+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fault_now) begin
          state_d = RESP;
        end else if (legal_now) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= fault_now;
      if (accept) fault_q <= fault_now;
      if (legal_now) begin
        we_q    <= we_i;
        uns_q   <= ld_unsigned_i;
        size_q  <= size_i;
        addr_q  <= addr_i[AW+1:0];
        wdata_q <= wdata_i;
      end
      // Commit whatever RESP presented so it holds afterwards.
      if (state_q == RESP) rdata_q <= rdata_o;
    end
  end

  // During RESP the fresh load result is presented straight from the RAM
  // read register; otherwise the held value.
  always_comb begin
    rdata_o = rdata_q;
    if (state_q == RESP) begin
      if (fault_q)    rdata_o = '0;
      else if (!we_q) rdata_o = ld_extend(ram_rdata >> {addr_q[1:0], 3'b000},
                                          size_q, uns_q);
    end
  end

  assign busy_o     = accept || (state_q == WAIT);
  assign done_o     = (state_q == RESP);
  assign misalign_o = misalign_q;

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads_o  <= '0;
      perf_stores_o <= '0;
      perf_stalls_o <= '0;
    end else begin
      if (done_o && !fault_q) begin
        if (we_q) perf_stores_o <= perf_stores_o + 32'd1;
        else      perf_loads_o  <= perf_loads_o + 32'd1;
      end
      if (busy_o && !fault_now) perf_stalls_o <= perf_stalls_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit plus on-chip data memory. It sits directly upstream of the write-back select stage and supplies its 32-bit memory operand. It performs byte, halfword and word accesses with sign or zero extension and byte-lane stores. A configurable wait-state FSM produces a stall to the core, plus a one-cycle completion pulse.

Parameters:
DEPTH, 1024, memory size in 32-bit words; power of two.
WAIT_CYCLES, 2, extra wait states per access; legal range 0..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active high
req  in  1  access request; sampled only in IDLE
we  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word, 11 illegal
ld_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads
addr  in  32  byte address
wdata  in  32  store data, right-aligned
rdata  out  32  load result to write-back stage
busy  out  1  stall to core (PC hold)
done  out  1  one-cycle completion pulse
misalign  out  1  fault flag, valid while done=1

Behaviour:
- Reset: clk and rst as above; reset is asynchronous and active-high.
  - While rst=1: state=IDLE, rdata=0, done=0, misalign=0, wait counter=0, latched request cleared.
  - Memory array is not reset.
  - Reset during WAIT aborts the access; no memory write occurs.
- States: IDLE, WAIT, RESP.
- IDLE with req=1:
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=00; size=11 is always a fault.
  - Fault: next state RESP with misalign=1, rdata=0, memory untouched.
  - Legal access: latch we/size/ld_unsigned/addr/wdata and load the counter with WAIT_CYCLES.
  - If WAIT_CYCLES=0, perform the access on this edge and go to RESP; otherwise go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where the counter equals 1, perform the access and go to RESP.
- RESP:
  - done=1 for exactly one cycle, then unconditional return to IDLE.
  - req is ignored in RESP.
- Latency: done rises WAIT_CYCLES+1 cycles after the req sample edge.
- busy is combinational: busy = (IDLE and req) or WAIT. It is 0 in RESP.
- Index: word index = addr[log2(DEPTH)+1:2]; higher address bits are ignored, so out-of-range addresses wrap.
- Store lanes:
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Half writes lanes {addr[1],1} and {addr[1],0} with wdata[15:0].
  - Word writes all lanes.
  - Unselected lanes are preserved.
- Load:
  - Extract the selected lane(s), then sign- or zero-extend per ld_unsigned; word loads ignore ld_unsigned.
  - rdata updates only on load completion and holds until the next load done.
  - Stores and faults leave rdata unchanged, except that a fault forces rdata to 0.
- misalign is registered: set together with done on a fault, cleared on the next cycle.

Optional Feature:
DMEM_PERF_EN
- Defined:
  - Adds outputs perf_loads[31:0], perf_stores[31:0] and perf_stalls[31:0].
  - perf_loads increments on each load done; perf_stores on each store done; perf_stalls on each cycle with busy=1.
  - Counters wrap at 2^32, reset to 0, and do not count faulted accesses.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum IDLE/WAIT/RESP;
  - a load-extension function taking lane, size and ld_unsigned.
- One sub-module, dmem_ram: a single-port word array with a 4-bit byte-enable write and a synchronous read. The FSM and lane logic stay in dmem_lsu.

Test Plan:
- WAIT_CYCLES=2; store word 0xDEADBEEF to 0x10, then load word 0x10 -> busy high 3 cycles, done at cycle 3, rdata=0xDEADBEEF.
- Store byte 0x80 to 0x11, then load byte signed 0x11 -> rdata=0xFFFFFF80; load unsigned -> 0x00000080; word 0x10 reads 0xDEAD80EF.
- Load half from 0x13 -> misalign=1 and done after 1 cycle, rdata=0, memory unchanged; size=11 at 0x0 -> misalign=1.
- WAIT_CYCLES=0; back-to-back req held high -> done every 2nd cycle, req during RESP ignored.
- Assert rst in the middle of a WAIT-state store to 0x20 -> outputs zeroed immediately; a later load of 0x20 returns the old value.
- Address 0x1000 with DEPTH=1024 -> aliases 0x0; with DMEM_PERF_EN, 2 loads + 1 store at WAIT_CYCLES=2 -> perf_loads=2, perf_stores=1, perf_stalls=9.
